// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle between issue, writeback and the Booth multiplier
// for the RV64M multiply sequencer.
interface mul_issue_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [63:0]  req_rs1;
  logic [63:0]  req_rs2;
  logic [4:0]   req_rd;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_data;
  logic [4:0]   resp_rd;
  logic         busy;
  logic         mul_valid;
  logic         mul_rs1_sign;
  logic         mul_rs2_sign;
  logic [63:0]  mul_rs1_data;
  logic [63:0]  mul_rs2_data;
  logic         mul_ready;
  logic [127:0] mul_result;

  modport slave (
    input  req_valid, req_op, req_rs1,
    input  req_rs2, req_rd, flush,
    input  resp_ready, mul_ready, mul_result,
    output req_ready, resp_valid,
    output resp_data, resp_rd, busy,
    output mul_valid, mul_rs1_sign,
    output mul_rs2_sign, mul_rs1_data,
    output mul_rs2_data
  );

  modport master (
    output req_valid, req_op, req_rs1,
    output req_rs2, req_rd, flush,
    output resp_ready, mul_ready, mul_result,
    input  req_ready, resp_valid,
    input  resp_data, resp_rd, busy,
    input  mul_valid, mul_rs1_sign,
    input  mul_rs2_sign, mul_rs1_data,
    input  mul_rs2_data
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// EXE-stage multiply sequencer: latches one RV64M request, drives the
// Booth multiplier, selects the 64-bit result, hands it to writeback.
module mul_issue_ctrl #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  mul_issue_ctrl_if.slave bus
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [63:0] rs1_q;
  logic [63:0] rs2_q;
  logic        s1_q;
  logic        s2_q;
  logic [63:0] data_q;

  logic        accept;
  logic        legal;
  logic        fast;
  logic        s1_d;
  logic        s2_d;
  logic        has_zero;
  logic        take;
  logic [63:0] sel;

  assign accept = bus.req_valid & bus.req_ready
                & ~bus.flush;

  always_comb begin
    s1_d  = 1'b0;
    s2_d  = 1'b0;
    legal = 1'b0;
    unique case (1'b1)
      bus.req_op == OP_MULH: begin
        s1_d  = 1'b1;
        s2_d  = 1'b1;
        legal = 1'b1;
      end
      bus.req_op == OP_MULHSU: begin
        s1_d  = 1'b1;
        legal = 1'b1;
      end
      bus.req_op == OP_MUL,
      bus.req_op == OP_MULHU,
      bus.req_op == OP_MULW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign has_zero = (bus.req_rs1 == '0)
                  | (bus.req_rs2 == '0);
  assign fast = ~legal | (ZERO_BYPASS & has_zero);

  always_comb begin
    sel = bus.mul_result[127:64];
    unique case (1'b1)
      op_q == OP_MUL:
        sel = bus.mul_result[63:0];
      op_q == OP_MULW:
        sel = {{32{bus.mul_result[31]}},
               bus.mul_result[31:0]};
      default: sel = bus.mul_result[127:64];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A flush in BUSY must still let the multiplier reach terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = fast ? DONE : BUSY;
      BUSY:
        if (bus.mul_ready)
          state_d = bus.flush ? IDLE : DONE;
        else if (bus.flush)
          state_d = DRAIN;
      DRAIN:
        if (bus.mul_ready) state_d = IDLE;
      DONE:
        if (bus.resp_ready | bus.flush)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = rst_n & (state_q == IDLE);
    bus.busy       = state_q != IDLE;
    bus.mul_valid  = (state_q == BUSY)
                   | (state_q == DRAIN);
    bus.resp_valid = state_q == DONE;
  end

  assign take = (state_q == BUSY) & bus.mul_ready
              & ~bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        rd_q  <= bus.req_rd;
        rs1_q <= bus.req_rs1;
        rs2_q <= bus.req_rs2;
        s1_q  <= s1_d;
        s2_q  <= s2_d;
      end
      if (accept & fast) data_q <= '0;
      else if (take)     data_q <= sel;
    end
  end

  assign bus.resp_data    = data_q;
  assign bus.resp_rd      = rd_q;
  assign bus.mul_rs1_data = rs1_q;
  assign bus.mul_rs2_data = rs2_q;
  assign bus.mul_rs1_sign = s1_q;
  assign bus.mul_rs2_sign = s2_q;

endmodule
